dmem_access_unit: RTL

- Byte/halfword/word load-store front end between the CPU core data port and the dual-port ideal memory.
- The memory reads asynchronously, writes synchronously, and writes whole words only. This block therefore converts CPU requests into word-indexed memory accesses.
- Sub-word stores become a read-modify-write: read on memory port 2, then write on the write port.
- Sub-word loads are lane-extracted and sign- or zero-extended. Results return over a valid/ready response handshake.

---
 rtl/dmem_pkg.sv | 35 +++
 rtl/dmem_lane_unit.sv | 43 ++++
 rtl/dmem_access_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory access unit: request sizes, FSM states
// and the fixed accept-to-response latencies of each request class.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int LAT_LD  = 2;
    localparam int LAT_ST  = 2;
    localparam int LAT_RMW = 3;
    localparam int LAT_ERR = 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LD   = 3'd1,
        S_RMW  = 3'd2,
        S_ST   = 3'd3,
        S_RESP = 3'd4
    } state_e;

    // Alignment fault for the given size at byte lane `lane`; size 3 is always illegal.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != 2'd0);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Little-endian lane handling: extract/extend for loads, lane merge for
// sub-word stores. Purely combinational.
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    input  logic [15:0] st_data,
    output logic [31:0] ld_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
        ld_data  = rdata;
        merged   = rdata;
        case (size)
            SZ_BYTE: begin
                ld_data = {{24{sext & byte_sel[7]}}, byte_sel};
                merged[{lane, 3'b000} +: 8] = st_data[7:0];
            end
            SZ_HALF: begin
                ld_data = {{16{sext & half_sel[15]}}, half_sel};
                if (lane[1]) begin
                    merged[31:16] = st_data;
                end else begin
                    merged[15:0] = st_data;
                end
            end
            default: begin
                ld_data = rdata;
                merged  = rdata;
            end
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// Byte/half/word load-store front end onto a word-only memory; sub-word stores
// are performed as read-modify-write through read port 2.
//
// state  | meaning
// IDLE   | ready for a request
// LD     | memory read, extracted load data registered
// RMW    | memory read, store lane merged into wbuf
// ST     | single-cycle word write of wbuf
// RESP   | response held until resp_ready
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic                  mem_rden,
    input  logic [31:0]           mem_rdata,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic                  mem_wren,
    output logic [31:0]           mem_wdata
);

    state_e                state_q, state_d;
    logic [1:0]            size_q, size_d;
    logic                  signed_q, signed_d;
    logic [1:0]            lane_q, lane_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [15:0]           wdata_q, wdata_d;
    logic [31:0]           wbuf_q, wbuf_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  req_err;
    logic [ADDR_WIDTH-1:0] req_idx;
    logic [31:0]           ld_data;
    logic [31:0]           st_merged;

    dmem_lane_unit u_lane (
        .size    (size_q),
        .sext    (signed_q),
        .lane    (lane_q),
        .rdata   (mem_rdata),
        .st_data (wdata_q),
        .ld_data (ld_data),
        .merged  (st_merged)
    );

    // Address bits above the memory size make the request out of range.
    always_comb begin
        req_err = misaligned(req_size, req_addr[1:0]) | ((req_addr >> ADDR_WIDTH) != 32'd0);
        req_idx = {2'b00, req_addr[ADDR_WIDTH-1:2]};
    end

    always_comb begin
        state_d    = state_q;
        size_d     = size_q;
        signed_d   = signed_q;
        lane_d     = lane_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        wbuf_d     = wbuf_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_rden   = 1'b0;
        mem_raddr  = '0;
        mem_wren   = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = 32'd0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    size_d   = req_size;
                    signed_d = req_signed;
                    lane_d   = req_addr[1:0];
                    idx_d    = req_idx;
                    wdata_d  = req_wdata[15:0];
                    rdata_d  = 32'd0;
                    err_d    = req_err;
                    if (req_err) begin
                        state_d = S_RESP;
                    end else if (!req_wr) begin
                        state_d = S_LD;
                    end else if (req_size == SZ_WORD) begin
                        wbuf_d  = req_wdata;
                        state_d = S_ST;
                    end else begin
                        state_d = S_RMW;
                    end
                end
            end
            S_LD: begin
                mem_rden  = 1'b1;
                mem_raddr = idx_q;
                rdata_d   = ld_data;
                state_d   = S_RESP;
            end
            S_RMW: begin
                mem_rden  = 1'b1;
                mem_raddr = idx_q;
                wbuf_d    = st_merged;
                state_d   = S_ST;
            end
            S_ST: begin
                mem_wren  = 1'b1;
                mem_waddr = idx_q;
                mem_wdata = wbuf_q;
                state_d   = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            size_q   <= 2'd0;
            signed_q <= 1'b0;
            lane_q   <= 2'd0;
            idx_q    <= '0;
            wdata_q  <= 16'd0;
            wbuf_q   <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            lane_q   <= lane_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            wbuf_q   <= wbuf_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
